// File: rtl/rt_jtag_tap_sampled.sv
// rt_jtag_tap_sampled
// Oversampled IEEE 1149.1 TAP responder. The JTAG pins are synchronised into
// clk_i and TCK is edge-detected, so the whole TAP runs on the system clock.
// It provides the 16-state TAP controller, a 5-bit IR, an IDCODE DR, BYPASS,
// and a USER DR with a capture/update handshake toward on-chip logic.
//
// Ports
//   clk_i          system clock
//   rst_ni         synchronous active-low reset
//   jtag_tck_i     asynchronous TCK pin
//   jtag_tms_i     asynchronous TMS pin
//   jtag_tdi_i     asynchronous TDI pin
//   jtag_trst_ni   asynchronous TRST pin, active low
//   jtag_td_o      TDO, changes only on a detected TCK falling edge
//   jtag_td_oe_o   TDO enable, high while in Shift-IR / Shift-DR
//   ir_o           current instruction register
//   user_rdata_i   data captured into the USER DR
//   user_capture_o one-cycle pulse when a USER capture happens
//   user_wdata_o   USER DR contents latched at update
//   user_wvalid_o  one-cycle pulse when a USER update happens
module rt_jtag_tap_sampled #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              jtag_tck_i,
  input  logic              jtag_tms_i,
  input  logic              jtag_tdi_i,
  input  logic              jtag_trst_ni,
  output logic              jtag_td_o,
  output logic              jtag_td_oe_o,
  output logic [4:0]        ir_o,
  input  logic [DATA_W-1:0] user_rdata_i,
  output logic              user_capture_o,
  output logic [DATA_W-1:0] user_wdata_o,
  output logic              user_wvalid_o
);

  localparam logic [31:0] IDCODE    = 32'h2495_11C3;
  localparam logic [4:0]  IR_IDCODE = 5'h01;
  localparam logic [4:0]  IR_USER   = 5'h10;

  // Standard 1149.1 state encoding
  localparam logic [3:0] TLR      = 4'hF;
  localparam logic [3:0] RTI      = 4'hC;
  localparam logic [3:0] SEL_DR   = 4'h7;
  localparam logic [3:0] CAP_DR   = 4'h6;
  localparam logic [3:0] SHIFT_DR = 4'h2;
  localparam logic [3:0] EXIT1_DR = 4'h1;
  localparam logic [3:0] PAUSE_DR = 4'h3;
  localparam logic [3:0] EXIT2_DR = 4'h0;
  localparam logic [3:0] UPD_DR   = 4'h5;
  localparam logic [3:0] SEL_IR   = 4'h4;
  localparam logic [3:0] CAP_IR   = 4'hE;
  localparam logic [3:0] SHIFT_IR = 4'hA;
  localparam logic [3:0] EXIT1_IR = 4'h9;
  localparam logic [3:0] PAUSE_IR = 4'hB;
  localparam logic [3:0] EXIT2_IR = 4'h8;
  localparam logic [3:0] UPD_IR   = 4'hD;

  logic tck_p0, tck_p1, tck_p2;
  logic tms_p0, tms_p1;
  logic tdi_p0, tdi_p1;
  logic trst_n_p0, trst_n_p1;

  logic              tck_rise, tck_fall;
  logic [3:0]        state, state_nxt;
  logic [4:0]        ir_sr;
  logic [31:0]       id_sr;
  logic              byp_sr;
  logic [DATA_W-1:0] user_sr;
  logic              sel_user, sel_id, dr_lsb;
  logic              enter_cap_dr, enter_upd_dr;

  // Stage p0/p1: two-flop synchronisers; tck_p2 is the extra TCK delay flop.
  // TRST comes out of reset asserted so the TAP stays in TLR until the pin
  // has been sampled.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tck_p0    <= 1'b0;
      tck_p1    <= 1'b0;
      tck_p2    <= 1'b0;
      trst_n_p0 <= 1'b0;
      trst_n_p1 <= 1'b0;
    end else begin
      tck_p0    <= jtag_tck_i;
      tck_p1    <= tck_p0;
      tck_p2    <= tck_p1;
      trst_n_p0 <= jtag_trst_ni;
      trst_n_p1 <= trst_n_p0;
    end
  end

  always_ff @(posedge clk_i) begin
    tms_p0 <= jtag_tms_i;
    tms_p1 <= tms_p0;
    tdi_p0 <= jtag_tdi_i;
    tdi_p1 <= tdi_p0;
  end

  assign tck_rise = tck_p1 & ~tck_p2;
  assign tck_fall = ~tck_p1 & tck_p2;

  always_comb begin
    state_nxt = state;
    unique case (state)
      TLR:      state_nxt = tms_p1 ? TLR      : RTI;
      RTI:      state_nxt = tms_p1 ? SEL_DR   : RTI;
      SEL_DR:   state_nxt = tms_p1 ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nxt = tms_p1 ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_nxt = tms_p1 ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_nxt = tms_p1 ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_nxt = tms_p1 ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_nxt = tms_p1 ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_nxt = tms_p1 ? SEL_DR   : RTI;
      SEL_IR:   state_nxt = tms_p1 ? TLR      : CAP_IR;
      CAP_IR:   state_nxt = tms_p1 ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_nxt = tms_p1 ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_nxt = tms_p1 ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_nxt = tms_p1 ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_nxt = tms_p1 ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_nxt = tms_p1 ? SEL_DR   : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  // Undefined opcodes fall through to BYPASS
  assign sel_user = (ir_o == IR_USER);
  assign sel_id   = (ir_o == IR_IDCODE);
  assign dr_lsb   = sel_user ? user_sr[0] : (sel_id ? id_sr[0] : byp_sr);

  // DR capture and update happen on the rising edge that enters the state,
  // so the handshake pulse lands the cycle right after that edge
  assign enter_cap_dr = (state == SEL_DR) && !tms_p1;
  assign enter_upd_dr = ((state == EXIT1_DR) || (state == EXIT2_DR)) && tms_p1;

  // Stage p2: TAP state, IR/DR shift registers, handshake and TDO
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= TLR;
      ir_o           <= IR_IDCODE;
      ir_sr          <= '0;
      id_sr          <= '0;
      byp_sr         <= 1'b0;
      user_sr        <= '0;
      user_wdata_o   <= '0;
      user_capture_o <= 1'b0;
      user_wvalid_o  <= 1'b0;
      jtag_td_o      <= 1'b0;
      jtag_td_oe_o   <= 1'b0;
    end else if (!trst_n_p1) begin
      state          <= TLR;
      ir_o           <= IR_IDCODE;
      user_capture_o <= 1'b0;
      user_wvalid_o  <= 1'b0;
      jtag_td_o      <= 1'b0;
      jtag_td_oe_o   <= 1'b0;
    end else begin
      user_capture_o <= 1'b0;
      user_wvalid_o  <= 1'b0;
      if (tck_rise) begin
        state <= state_nxt;
        case (state)
          CAP_IR:   ir_sr <= 5'b00001;
          SHIFT_IR: ir_sr <= {tdi_p1, ir_sr[4:1]};
          UPD_IR:   ir_o  <= ir_sr;
          SHIFT_DR: begin
            if (sel_user)    user_sr <= {tdi_p1, user_sr[DATA_W-1:1]};
            else if (sel_id) id_sr   <= {tdi_p1, id_sr[31:1]};
            else             byp_sr  <= tdi_p1;
          end
          default: ;
        endcase
        if (enter_cap_dr) begin
          if (sel_user) begin
            user_sr        <= user_rdata_i;
            user_capture_o <= 1'b1;
          end else if (sel_id) begin
            id_sr <= IDCODE;
          end else begin
            byp_sr <= 1'b0;
          end
        end
        if (enter_upd_dr && sel_user) begin
          user_wdata_o  <= user_sr;
          user_wvalid_o <= 1'b1;
        end
      end
      if (tck_fall) begin
        jtag_td_oe_o <= (state == SHIFT_IR) || (state == SHIFT_DR);
        if (state == SHIFT_IR)      jtag_td_o <= ir_sr[0];
        else if (state == SHIFT_DR) jtag_td_o <= dr_lsb;
        else                        jtag_td_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rt_jtag_tap_sampled.sv
`timescale 1ns/1ps
module tb_rt_jtag_tap_sampled;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tck = 1'b0, tms = 1'b1, tdi = 1'b0, trst_n = 1'b1;
  logic        td, td_oe, cap, wvalid;
  logic [4:0]  ir;
  logic [31:0] rdata = 32'h0, wdata;

  always #5 clk = ~clk;

  rt_jtag_tap_sampled #(.DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .jtag_tck_i(tck), .jtag_tms_i(tms), .jtag_tdi_i(tdi), .jtag_trst_ni(trst_n),
    .jtag_td_o(td), .jtag_td_oe_o(td_oe), .ir_o(ir),
    .user_rdata_i(rdata), .user_capture_o(cap),
    .user_wdata_o(wdata), .user_wvalid_o(wvalid)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural TAP model, advanced once per complete TCK period
  typedef enum int {M_TLR, M_RTI, M_SELDR, M_CAPDR, M_SHDR, M_EX1DR, M_PSDR, M_EX2DR,
                    M_UPDDR, M_SELIR, M_CAPIR, M_SHIR, M_EX1IR, M_PSIR, M_EX2IR, M_UPDIR} tap_e;
  tap_e        m_st = M_TLR;
  logic [4:0]  m_ir = 5'h01;
  bit          m_td = 1'b0, m_oe = 1'b0;
  bit          ir_q[$], dr_q[$], out_q[$];
  int          m_cap = 0;
  logic [31:0] exp_wq[$];

  function automatic tap_e tap_next(tap_e s, bit t);
    case (s)
      M_TLR:   return t ? M_TLR   : M_RTI;
      M_RTI:   return t ? M_SELDR : M_RTI;
      M_SELDR: return t ? M_SELIR : M_CAPDR;
      M_CAPDR: return t ? M_EX1DR : M_SHDR;
      M_SHDR:  return t ? M_EX1DR : M_SHDR;
      M_EX1DR: return t ? M_UPDDR : M_PSDR;
      M_PSDR:  return t ? M_EX2DR : M_PSDR;
      M_EX2DR: return t ? M_UPDDR : M_SHDR;
      M_UPDDR: return t ? M_SELDR : M_RTI;
      M_SELIR: return t ? M_TLR   : M_CAPIR;
      M_CAPIR: return t ? M_EX1IR : M_SHIR;
      M_SHIR:  return t ? M_EX1IR : M_SHIR;
      M_EX1IR: return t ? M_UPDIR : M_PSIR;
      M_PSIR:  return t ? M_EX2IR : M_PSIR;
      M_EX2IR: return t ? M_UPDIR : M_SHIR;
      M_UPDIR: return t ? M_SELDR : M_RTI;
      default: return M_TLR;
    endcase
  endfunction

  task automatic model_step(input bit t, input bit d);
    logic [31:0] w;
    int n;
    w = 32'h0;
    case (m_st)
      M_CAPIR: begin
        ir_q.delete();
        ir_q.push_back(1'b1);
        repeat (4) ir_q.push_back(1'b0);
      end
      M_SHIR: begin
        ir_q.push_back(d);
        void'(ir_q.pop_front());
      end
      M_UPDIR: for (int i = 0; i < 5; i++) m_ir[i] = ir_q[i];
      M_CAPDR: begin
        dr_q.delete();
        n = 1;
        if (m_ir == 5'h01) begin w = 32'h2495_11C3; n = 32; end
        else if (m_ir == 5'h10) begin w = rdata; n = 32; m_cap++; end
        for (int i = 0; i < n; i++) dr_q.push_back(w[i]);
      end
      M_SHDR: begin
        dr_q.push_back(d);
        void'(dr_q.pop_front());
      end
      M_UPDDR: if (m_ir == 5'h10) begin
        for (int i = 0; i < dr_q.size() && i < 32; i++) w[i] = dr_q[i];
        exp_wq.push_back(w);
      end
      default: ;
    endcase
    m_st = tap_next(m_st, t);
    m_oe = (m_st == M_SHIR) || (m_st == M_SHDR);
    m_td = 1'b0;
    if (m_st == M_SHIR && ir_q.size() > 0) m_td = ir_q[0];
    if (m_st == M_SHDR && dr_q.size() > 0) m_td = dr_q[0];
  endtask

  // Pulse monitor: records every handshake pulse and the data seen with it
  int          obs_cap = 0, wide = 0;
  logic [31:0] obs_wq[$];
  logic        cap_d = 1'b0, wv_d = 1'b0;
  always @(negedge clk) begin
    if (cap) obs_cap++;
    if (wvalid) obs_wq.push_back(wdata);
    if ((cap && cap_d) || (wvalid && wv_d)) wide++;
    cap_d <= cap;
    wv_d  <= wvalid;
  end

  // One TCK period: set TMS/TDI, rise, fall, then compare against the model
  task automatic tck_cycle(input bit t, input bit d);
    tms = t;
    tdi = d;
    repeat (2) @(negedge clk);
    tck = 1'b1;
    repeat (6) @(negedge clk);
    tck = 1'b0;
    repeat (6) @(negedge clk);
    model_step(t, d);
    chk("tdo", 32'(td), 32'(m_td));
    chk("tdo_oe", 32'(td_oe), 32'(m_oe));
    chk("ir", 32'(ir), 32'(m_ir));
    if (m_oe) out_q.push_back(td);
  endtask

  function automatic logic [31:0] out_word();
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < out_q.size() && i < 32; i++) w[i] = out_q[i];
    return w;
  endfunction

  task automatic check_pulses();
    chk("capture_count", 32'(obs_cap), 32'(m_cap));
    chk("wvalid_count", 32'(obs_wq.size()), 32'(exp_wq.size()));
    while (obs_wq.size() > 0 && exp_wq.size() > 0)
      chk("wdata_at_wvalid", obs_wq.pop_front(), exp_wq.pop_front());
    obs_wq.delete();
    exp_wq.delete();
    chk("pulse_width", 32'(wide), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tck = 1'b0; tms = 1'b1; tdi = 1'b0; trst_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    m_st = M_TLR; m_ir = 5'h01; m_td = 1'b0; m_oe = 1'b0;
    ir_q.delete(); dr_q.delete();
  endtask

  task automatic apply_trst();
    trst_n = 1'b0;
    repeat (4) @(negedge clk);
    trst_n = 1'b1;
    repeat (4) @(negedge clk);
    m_st = M_TLR; m_ir = 5'h01; m_td = 1'b0; m_oe = 1'b0;
    chk("trst_tdo_oe", 32'(td_oe), 32'(m_oe));
    chk("trst_tdo", 32'(td), 32'(m_td));
    chk("trst_ir", 32'(ir), 32'(m_ir));
  endtask

  // From Run-Test/Idle back to Run-Test/Idle
  task automatic shift_ir(input logic [4:0] v);
    tck_cycle(1, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int i = 0; i < 5; i++) tck_cycle(i == 4, v[i]);
    tck_cycle(1, 0); tck_cycle(0, 0);
  endtask

  // From Run-Test/Idle back to Run-Test/Idle; pause_at < 0 means no pause
  task automatic shift_dr(input int n, input logic [31:0] din, input int pause_at);
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int i = 0; i < n; i++) begin
      tck_cycle((i == n - 1) || (i == pause_at), din[i]);
      if (i == pause_at && i != n - 1) begin
        for (int k = 0; k < 10; k++) begin
          tck_cycle(0, 0);
          chk("pause_oe", 32'(td_oe), 32'd0);
        end
        tck_cycle(1, 0);
        tck_cycle(0, 0);
      end
    end
    tck_cycle(1, 0); tck_cycle(0, 0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cap0;
    logic [4:0] op;

    // Reset state
    do_reset();
    chk("rst_tdo", 32'(td), 32'd0);
    chk("rst_tdo_oe", 32'(td_oe), 32'd0);
    chk("rst_ir", 32'(ir), 32'h01);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_capture", 32'(cap), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);

    // IDCODE read after TLR
    repeat (5) tck_cycle(1, 0);
    tck_cycle(0, 0);
    out_q.delete();
    shift_dr(32, 32'h0, -1);
    chk("idcode_tdo", out_word(), 32'h2495_11C3);
    chk("idcode_nbits", 32'(out_q.size()), 32'd32);
    chk("idcode_ir", 32'(ir), 32'h01);

    // IR capture pattern and BYPASS
    out_q.delete();
    shift_ir(5'h1F);
    chk("ir_capture_tdo", out_word(), 32'h01);
    chk("bypass_ir", 32'(ir), 32'h1F);
    out_q.delete();
    shift_dr(5, 32'h0D, -1);
    chk("bypass_tdo", out_word(), 32'h1A);
    check_pulses();

    // USER write/read
    rdata = 32'hCAFE_F00D;
    shift_ir(5'h10);
    cap0 = obs_cap;
    out_q.delete();
    shift_dr(32, 32'h0001_0001, -1);
    chk("user_tdo", out_word(), 32'hCAFE_F00D);
    chk("user_capture_pulses", 32'(obs_cap - cap0), 32'd1);
    chk("user_wvalid_pulses", 32'(obs_wq.size()), 32'd1);
    chk("user_wdata_pulse", (obs_wq.size() > 0) ? obs_wq[0] : 32'hxxxx_xxxx, 32'h0001_0001);
    chk("user_wdata_hold", wdata, 32'h0001_0001);
    check_pulses();

    // Undefined opcode acts as BYPASS
    shift_ir(5'h07);
    chk("undef_ir", 32'(ir), 32'h07);
    cap0 = obs_cap;
    out_q.delete();
    shift_dr(5, 32'h0D, -1);
    chk("undef_bypass_tdo", out_word(), 32'h1A);
    chk("undef_no_capture", 32'(obs_cap - cap0), 32'd0);
    chk("undef_no_wvalid", 32'(obs_wq.size()), 32'd0);
    check_pulses();

    // TRST in the middle of a USER shift
    shift_ir(5'h10);
    rdata = 32'h1234_5678;
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int i = 0; i < 10; i++) tck_cycle(0, 1'($urandom_range(0, 1)));
    apply_trst();
    chk("trst_oe_lit", 32'(td_oe), 32'd0);
    chk("trst_ir_lit", 32'(ir), 32'h01);
    tck_cycle(1, 0);
    chk("trst_no_wvalid", 32'(obs_wq.size()), 32'd0);
    check_pulses();
    tck_cycle(0, 0);
    out_q.delete();
    shift_dr(32, 32'h0, -1);
    chk("post_trst_idcode", out_word(), 32'h2495_11C3);

    // Pause-DR in the middle of a USER shift
    shift_ir(5'h10);
    rdata = 32'hA5C3_0F96;
    out_q.delete();
    shift_dr(32, 32'h3C5A_9617, 12);
    chk("pause_user_tdo", out_word(), 32'hA5C3_0F96);
    chk("pause_user_wdata", wdata, 32'h3C5A_9617);
    check_pulses();

    // Randomised TAP traffic checked against the model every TCK period
    for (int n = 0; n < 500; n++) begin
      if ((m_st == M_TLR || m_st == M_RTI) && ($urandom_range(0, 3) == 0))
        rdata = $urandom;
      if (m_st == M_RTI && $urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0: op = 5'h01;
          1: op = 5'h10;
          2: op = 5'h1F;
          3: op = 5'h10;
          default: op = 5'($urandom);
        endcase
        shift_ir(op);
      end else if (m_st != M_CAPDR && m_st != M_UPDDR && $urandom_range(0, 99) == 0) begin
        apply_trst();
      end else begin
        tck_cycle($urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)));
      end
    end
    repeat (5) tck_cycle(1, 0);
    check_pulses();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
